// File: rtl/csync_decoder.sv
// Composite-sync decoder for the AIV capture path: classifies csync pulses by width,
// counts lines, detects vertical sync and field parity, and tracks timing lock.
module csync_decoder #(
    parameter int LINE_CYCLES = 5184,
    parameter int MIN_PULSE   = 40,
    parameter int EQ_MAX      = 280,
    parameter int HSYNC_MAX   = 560,
    parameter int BROAD_MIN   = 1200,
    parameter int TIMEOUT     = 16384,
    parameter int LOCK_FIELDS = 2,
    parameter int MIN_LINES   = 300,
    parameter int MAX_LINES   = 320
) (
    input  logic       sysClk,
    input  logic       nReset,
    input  logic       csync,
    output logic       hsyncStrobe,
    output logic       vsyncStrobe,
    output logic       field,
    output logic [9:0] lineNumber,
    output logic       locked,
    output logic [1:0] pulseType
);
    localparam logic [11:0] MIN_W     = 12'(MIN_PULSE);
    localparam logic [11:0] EQ_W      = 12'(EQ_MAX);
    localparam logic [11:0] HS_W      = 12'(HSYNC_MAX);
    localparam logic [11:0] BR_W      = 12'(BROAD_MIN);
    localparam logic [12:0] LINE_3Q   = 13'((3 * LINE_CYCLES) / 4);
    localparam logic [12:0] LINE_1Q   = 13'(LINE_CYCLES / 4);
    localparam logic [14:0] TIMEOUT_C = 15'(TIMEOUT);
    localparam logic [3:0]  LOCK_C    = 4'(LOCK_FIELDS);
    localparam logic [10:0] MIN_L     = 11'(MIN_LINES);
    localparam logic [10:0] MAX_L     = 11'(MAX_LINES);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} lock_t;

    logic        sync_a, sync_b, sync_d;
    logic [11:0] width;
    logic [12:0] since_line, period_latch;
    logic [14:0] idle_count;
    logic [1:0]  prev_type, cls;
    logic [3:0]  good_count, good_next;
    lock_t       state, state_next;

    logic        fall, rise, valid, line_ev, vs_ev, timeout_hit, good_field;
    logic [10:0] field_lines;

    assign fall        = sync_d & ~sync_b;
    assign rise        = ~sync_d & sync_b;
    assign valid       = rise && (cls != 2'd0);
    assign line_ev     = valid && (period_latch >= LINE_3Q);
    assign vs_ev       = rise && (cls == 2'd3) && (prev_type != 2'd3);
    assign timeout_hit = (idle_count == TIMEOUT_C);
    assign field_lines = {1'b0, lineNumber} + 11'd1;
    assign good_field  = (field_lines >= MIN_L) && (field_lines <= MAX_L);

    always_comb begin
        cls = 2'd0;
        if (width >= BR_W)       cls = 2'd3;
        else if (width >= HS_W)  cls = 2'd0;
        else if (width >= EQ_W)  cls = 2'd2;
        else if (width >= MIN_W) cls = 2'd1;
    end

    always_ff @(posedge sysClk) begin
        if (!nReset) begin
            sync_a       <= 1'b1;
            sync_b       <= 1'b1;
            sync_d       <= 1'b1;
            width        <= '0;
            since_line   <= '0;
            period_latch <= '0;
            idle_count   <= '0;
            prev_type    <= '0;
            hsyncStrobe  <= 1'b0;
            vsyncStrobe  <= 1'b0;
            field        <= 1'b0;
            lineNumber   <= '0;
            locked       <= 1'b0;
            pulseType    <= '0;
        end else begin
            sync_a <= csync;
            sync_b <= sync_a;
            sync_d <= sync_b;

            // The falling-edge cycle is itself the first low cycle, so width = low cycles at release.
            if (fall)                             width <= 12'd1;
            else if (!sync_b && width != 12'hFFF) width <= width + 12'd1;

            if (line_ev)                   since_line <= {1'b0, width} + 13'd1;
            else if (since_line != 13'h1FFF) since_line <= since_line + 13'd1;

            // A rejected pulse must not leave its own edge time in the period latch.
            if (fall || (rise && !valid)) period_latch <= since_line;

            if (fall)                        idle_count <= '0;
            else if (idle_count != TIMEOUT_C) idle_count <= idle_count + 15'd1;

            if (valid) prev_type <= cls;
            if (rise)  pulseType <= cls;

            hsyncStrobe <= line_ev;
            vsyncStrobe <= vs_ev;

            if (vs_ev) field <= (period_latch >= LINE_1Q) && (period_latch < LINE_3Q);

            if (timeout_hit || vs_ev)          lineNumber <= '0;
            else if (line_ev && lineNumber != 10'h3FF) lineNumber <= lineNumber + 10'd1;

            locked <= (state_next == LOCKED);
        end
    end

    always_ff @(posedge sysClk) begin
        if (!nReset) begin
            state      <= UNLOCKED;
            good_count <= '0;
        end else begin
            state      <= state_next;
            good_count <= good_next;
        end
    end

    always_comb begin
        state_next = state;
        good_next  = good_count;
        if (timeout_hit) begin
            state_next = UNLOCKED;
            good_next  = '0;
        end else if (vs_ev) begin
            case (state)
                UNLOCKED: begin
                    state_next = ACQUIRE;
                    good_next  = '0;
                end
                ACQUIRE: begin
                    if (good_field) begin
                        good_next = good_count + 4'd1;
                        if (good_count + 4'd1 >= LOCK_C) state_next = LOCKED;
                    end else begin
                        good_next = '0;
                    end
                end
                LOCKED: begin
                    if (!good_field) begin
                        state_next = ACQUIRE;
                        good_next  = '0;
                    end
                end
                default: begin
                    state_next = UNLOCKED;
                    good_next  = '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csync_decoder.sv
// Bench for csync_decoder: randomized PAL-like field sequences (time-scaled parameters)
// checked pulse by pulse against a rule-level reference model.
module tb_csync_decoder;
    localparam int LC   = 192;
    localparam int HALF = LC / 2;
    localparam int MP   = 4;
    localparam int EQ   = 12;
    localparam int HS   = 24;
    localparam int BR   = 48;
    localparam int TO   = 1000;
    localparam int LF   = 2;
    localparam int MINL = 30;
    localparam int MAXL = 40;

    logic       sysClk = 1'b0;
    logic       nReset;
    logic       csync;
    logic       hsyncStrobe, vsyncStrobe, field, locked;
    logic [9:0] lineNumber;
    logic [1:0] pulseType;

    csync_decoder #(
        .LINE_CYCLES(LC), .MIN_PULSE(MP), .EQ_MAX(EQ), .HSYNC_MAX(HS), .BROAD_MIN(BR),
        .TIMEOUT(TO), .LOCK_FIELDS(LF), .MIN_LINES(MINL), .MAX_LINES(MAXL)
    ) dut (
        .sysClk(sysClk), .nReset(nReset), .csync(csync),
        .hsyncStrobe(hsyncStrobe), .vsyncStrobe(vsyncStrobe), .field(field),
        .lineNumber(lineNumber), .locked(locked), .pulseType(pulseType)
    );

    always #5 sysClk = ~sysClk;

    int     checks = 0;
    int     errors = 0;
    longint t = 0;
    int     g = 0;

    // reference model state: lock 0 = unlocked, 1 = acquiring, 2 = locked
    int     m_line = 0, m_field = 0, m_lock = 0, m_good = 0, m_prev = 0, m_ptype = 0;
    longint last_line_fall = 0;
    int     exp_h = 0, exp_v = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, expv, t);
        end
    endtask

    task automatic hold(input logic v, input int n);
        csync = v;
        repeat (n) begin
            @(negedge sysClk);
            t++;
        end
    endtask

    task automatic model_pulse(input longint tf, input int w);
        int     typ, fl;
        longint per;
        bit     lev, vev;
        if (w < MP)        typ = 0;
        else if (w < EQ)   typ = 1;
        else if (w < HS)   typ = 2;
        else if (w >= BR)  typ = 3;
        else               typ = 0;
        m_ptype = typ;
        exp_h = 0;
        exp_v = 0;
        if (typ == 0) return;
        per = tf - last_line_fall;
        if (per > 8191) per = 8191;
        lev = (per >= (3 * LC) / 4);
        vev = (typ == 3) && (m_prev != 3);
        if (vev) begin
            fl      = m_line + 1;
            m_field = (per >= LC / 4 && per < (3 * LC) / 4) ? 1 : 0;
            m_line  = 0;
            if (m_lock == 0) begin
                m_lock = 1; m_good = 0;
            end else if (fl < MINL || fl > MAXL) begin
                m_lock = 1; m_good = 0;
            end else if (m_lock == 1) begin
                m_good++;
                if (m_good >= LF) m_lock = 2;
            end
        end else if (lev && m_line < 1023) begin
            m_line++;
        end
        if (lev) last_line_fall = tf;
        m_prev = typ;
        exp_h = lev ? 1 : 0;
        exp_v = vev ? 1 : 0;
    endtask

    // Low for w cycles then high for gap cycles; outputs checked around the strobe slot.
    task automatic pulse(input int w, input int gap);
        model_pulse(t, w);
        hold(1'b0, w);
        hold(1'b1, 2);
        check("hsync_early", 32'(hsyncStrobe), 0);
        hold(1'b1, 1);
        check("hsync", 32'(hsyncStrobe), 32'(exp_h));
        check("vsync", 32'(vsyncStrobe), 32'(exp_v));
        hold(1'b1, 1);
        check("hsync_width", 32'(hsyncStrobe), 0);
        check("pulse_type", 32'(pulseType), 32'(m_ptype));
        check("line_number", 32'(lineNumber), 32'(m_line));
        check("field", 32'(field), 32'(m_field));
        check("locked", 32'(locked), 32'(m_lock == 2));
        hold(1'b1, gap - 4);
    endtask

    // One field of h half-lines: 5 equalising, 5 broad, 5 equalising, then line syncs on
    // the global line grid; odd h makes the vertical sequence alternate line/mid-line.
    task automatic run_field(input int h, input bit glitch);
        int w, w2;
        for (int s = 0; s < h; s++) begin
            if (s < 5 || (s >= 10 && s < 15)) begin
                w = int'($urandom_range(MP + 1, EQ - 1));
                pulse(w, HALF - w);
            end else if (s < 15) begin
                w = int'($urandom_range(BR + 2, 70));
                pulse(w, HALF - w);
            end else if (g % 2 == 0) begin
                w = int'($urandom_range(EQ + 1, HS - 1));
                pulse(w, HALF - w);
            end else if (glitch && $urandom_range(0, 3) == 0) begin
                w  = int'($urandom_range(1, MP - 1));
                w2 = int'($urandom_range(HS + 1, BR - 2));
                pulse(w, 40 - w);
                pulse(w2, 56 - w2);
            end else begin
                hold(1'b1, HALF);
            end
            g++;
        end
    endtask

    initial begin
        nReset = 1'b0;
        csync  = 1'b1;
        @(negedge sysClk);
        for (int i = 0; i < 10; i++) begin
            csync = logic'($urandom_range(0, 1));
            @(negedge sysClk);
            t++;
        end
        check("rst_hsync", 32'(hsyncStrobe), 0);
        check("rst_vsync", 32'(vsyncStrobe), 0);
        check("rst_field", 32'(field), 0);
        check("rst_line", 32'(lineNumber), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_ptype", 32'(pulseType), 0);
        hold(1'b1, 2);
        nReset = 1'b1;
        last_line_fall = t;
        hold(1'b1, 300);

        for (int f = 0; f < 4; f++) run_field(71, f == 2);
        check("locked_after_good_fields", 32'(locked), 1);
        run_field(51, 1'b0);
        for (int f = 0; f < 3; f++) run_field(71, f == 1);
        check("relocked", 32'(locked), 1);

        hold(1'b1, TO + 50);
        m_lock = 0; m_good = 0; m_line = 0;
        check("timeout_locked", 32'(locked), 0);
        check("timeout_line", 32'(lineNumber), 0);
        check("timeout_strobe", 32'(hsyncStrobe), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/csync_decoder.md
Name: csync_decoder

Overview:
- Separates the composite sync from the BBC Master AIV input (active-low csync) into per-line and per-field timing events for the AIV capture path.
- It is the receive-side counterpart of the SCART composite-sync generator: it classifies sync pulses by width, counts lines through vertical blanking, identifies the field, and reports lock.
- Runs in the sysClk domain (pixel clock x6, nominal 81 MHz). It feeds the AIV framebuffer write addressing.

Parameters:
- LINE_CYCLES, 5184, nominal line period in sysClk cycles (64 us).
- MIN_PULSE, 40, low pulses shorter than this are glitches.
- EQ_MAX, 280, upper width bound (exclusive) of an equalising pulse.
- HSYNC_MAX, 560, upper width bound (exclusive) of a line-sync pulse.
- BROAD_MIN, 1200, lower width bound (inclusive) of a broad (vertical) pulse.
- TIMEOUT, 16384, cycles without any csync falling edge before lock is dropped.
- LOCK_FIELDS, 2, consecutive good fields required to assert locked.
- MIN_LINES, 300, minimum lines for a field to count as good.
- MAX_LINES, 320, maximum lines for a field to count as good.

Ports:
- sysClk  input  1  system clock (pixel clock x6).
- nReset  input  1  synchronous, active-low reset.
- csync  input  1  raw AIV composite sync, active low, asynchronous to sysClk.
- hsyncStrobe  output  1  one-cycle pulse per counted line.
- vsyncStrobe  output  1  one-cycle pulse at the first broad pulse of a field.
- field  output  1  0 = first field, 1 = second field; updated at vsyncStrobe.
- lineNumber  output  10  line index within the field, 0 at vsync.
- locked  output  1  high while the sync timing is valid.
- pulseType  output  2  last classified pulse: 0 glitch/invalid, 1 equalising, 2 line sync, 3 broad.

Behaviour:
- Reset: the clock is sysClk; reset is synchronous and active-low (nReset).
  - While nReset is low, every output is 0, all counters are cleared, and the synchroniser flops are set to 1 (idle high).
  - Reset asserted mid-pulse abandons that pulse; the first falling edge after release starts a fresh measurement.
- Input conditioning:
  - csync passes through a 2-flop synchroniser, then an edge detector on the synchronised value.
  - All timing below refers to the synchronised signal.
- Width counter (12 bit, saturating at 4095):
  - Cleared on a falling edge.
  - Increments while the signal is low.
- sinceLine counter (13 bit, saturating at 8191):
  - Increments every cycle.
  - Its value is latched to periodLatch on each falling edge.
- Classification on each rising edge, using w = width counter:
  - w < MIN_PULSE: glitch.
  - MIN_PULSE <= w < EQ_MAX: equalising.
  - EQ_MAX <= w < HSYNC_MAX: line sync.
  - w >= BROAD_MIN: broad.
  - HSYNC_MAX <= w < BROAD_MIN: invalid.
  - pulseType updates one cycle after the rising edge.
  - A glitch or invalid pulse changes nothing else. Its falling edge does not count: periodLatch is restored to the pre-edge value plus elapsed time, i.e. sinceLine is not disturbed.
- Line event: a valid pulse (equalising, line sync or broad) with periodLatch >= (3*LINE_CYCLES)/4.
  - lineNumber increments, saturating at 1023.
  - sinceLine is reloaded with w + 1, which references it to the falling edge.
  - hsyncStrobe pulses for 1 cycle. Latency is 1 cycle after the synchronised rising edge (3 cycles after the raw edge).
  - Valid pulses at half-line spacing (equalising/serration) do not increment.
- Vsync event: a broad pulse whose predecessor valid pulse was not broad.
  - vsyncStrobe pulses for 1 cycle, in the same cycle as any hsyncStrobe.
  - field is set to 1 if LINE_CYCLES/4 <= periodLatch < (3*LINE_CYCLES)/4 (sequence starts mid-line); otherwise field is 0.
  - The completed field's line count is fieldLines = lineNumber + 1.
  - lineNumber is then set to 0. This takes precedence over a simultaneous line event.
- Lock state machine:
  - States: UNLOCKED, ACQUIRE, LOCKED.
  - UNLOCKED -> ACQUIRE on the first vsync event; goodCount = 0.
  - ACQUIRE: each vsync with MIN_LINES <= fieldLines <= MAX_LINES increments goodCount. At goodCount == LOCK_FIELDS -> LOCKED, and locked = 1 from the next cycle. A bad fieldLines resets goodCount to 0.
  - LOCKED: a bad fieldLines -> ACQUIRE (goodCount = 0) and locked = 0.
  - Any state: TIMEOUT cycles without a synchronised falling edge -> UNLOCKED, locked = 0, lineNumber = 0. Timeout counter is 15 bit and cleared on every falling edge.
  - hsyncStrobe and vsyncStrobe continue regardless of lock state.
- Saturation: counters never wrap. A stuck-low input saturates the width counter and the pulse classifies as broad on release.

Test Plan:
- Reset: hold nReset low 10 cycles with csync toggling -> all outputs 0; first vsync after release moves the FSM to ACQUIRE only.
- Line sync: 5184-cycle lines with 381-cycle low pulses -> hsyncStrobe 3 cycles after each raw rising edge, pulseType = 2, lineNumber +1 per line.
- PAL field sequence: 312.5-line fields, 190-cycle equalising pulses, 2211-cycle broad pulses -> vsyncStrobe once per field, field alternates 0/1, lineNumber equals 0 after vsync, locked = 1 after the 2nd good field.
- Glitches: inject a 20-cycle low and a 800-cycle low mid-line -> pulseType = 0, no strobes, lineNumber unchanged, next hsync still on time.
- Bad field: one field of 250 lines while LOCKED -> locked drops at that vsync; reacquires after 2 further good fields.
- Timeout: hold csync high 16384 cycles while LOCKED -> locked = 0, lineNumber = 0, state UNLOCKED.
